// File: rtl/final_logic_router_pkg.sv
// Shared definitions for the final logic router: arbitration mode codes,
// default widths and helpers that locate the destination field in a word.
package final_logic_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;

  localparam int DEF_W      = 6;
  localparam int DEF_DEST_W = 2;

  // LSB of the destination field, which occupies the top DEST_W bits of a word.
  function automatic int dest_lsb(input int w, input int dest_w);
    return w - dest_w;
  endfunction

  // Pointer width that stays legal when there is only one requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/final_logic_router_if.sv
// VC-FIFO / destination-FIFO bundle for the final logic router; the router
// sits on the slave side, the FIFO environment on the master side.
interface final_logic_router_if
  import final_logic_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_VC   = 2,
  parameter int N_DEST = 2,
  parameter int ERR_W  = 8
);

  logic [N_VC*W-1:0]   data_out_VC;
  logic [N_VC-1:0]     empty_fifo_VC;
  logic [N_VC-1:0]     pop_VC_fifo;
  logic [N_DEST-1:0]   full_D;
  logic [N_DEST-1:0]   push_D;
  logic [N_DEST*W-1:0] data_out_D;
  logic [N_VC-1:0]     error_VC;
  logic [ERR_W-1:0]    err_count;

  modport master (
    output data_out_VC, empty_fifo_VC, full_D,
    input  pop_VC_fifo, push_D, data_out_D, error_VC, err_count
  );

  modport slave (
    input  data_out_VC, empty_fifo_VC, full_D,
    output pop_VC_fifo, push_D, data_out_D, error_VC, err_count
  );

endinterface

// File: rtl/final_logic_router_rr_arbiter.sv
// One-hot arbiter: round-robin starting after the last winner, or fixed
// priority with index 0 highest. The pointer only moves on a grant.
module rr_arbiter
  import final_logic_pkg::*;
#(
  parameter int N     = 2,
  parameter int MODE  = MODE_RR,
  localparam int PTR_W = ptr_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [N-1:0]     gnt_next;
  int               idx;

  always_comb begin
    gnt_next = '0;
    ptr_next = ptr_reg;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (MODE == MODE_PRIO) ? (i - 1) : ((int'(ptr_reg) + i) % N);
      if (gnt_next == '0 && req[idx]) begin
        gnt_next[idx] = 1'b1;
        ptr_next      = PTR_W'(idx);
      end
    end
  end

  // Reset to the last index so index 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= PTR_W'(N - 1);
    end else if (advance && (gnt_next != '0)) begin
      ptr_reg <= ptr_next;
    end
  end

  assign gnt = gnt_next;
  assign ptr = ptr_reg;

endmodule

// File: rtl/final_logic_router.sv
// Drains N_VC show-ahead VC FIFOs into N_DEST destination FIFOs, one word per
// cycle, steering on the destination field and dropping out-of-range words.
module final_logic_router
  import final_logic_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_VC   = 2,
  parameter int N_DEST = 2,
  parameter int DEST_W = DEF_DEST_W,
  parameter int MODE   = MODE_RR,
  parameter int ERR_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  final_logic_router_if.slave bus
);

  localparam int DEST_LSB = dest_lsb(W, DEST_W);
  localparam int PTR_W    = ptr_width(N_VC);

  logic [W-1:0]        head     [N_VC];
  logic [N_DEST-1:0]   dest_hit [N_VC];
  logic [N_VC-1:0]     valid;
  logic [N_VC-1:0]     eligible;
  logic [N_VC-1:0]     gnt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [W-1:0]        sel_word;
  logic [N_DEST-1:0]   sel_hit;
  logic [N_VC-1:0]     drop_next;

  logic [N_DEST-1:0]   push_D_reg;
  logic [N_DEST*W-1:0] data_out_D_reg;
  logic [N_VC-1:0]     error_VC_reg;
  logic [ERR_W-1:0]    err_count_reg;

  // A head aimed at a full destination stalls only its own VC.
  generate
    for (genvar gi = 0; gi < N_VC; gi++) begin : g_vc
      assign head[gi] = bus.data_out_VC[gi*W +: W];
      for (genvar gd = 0; gd < N_DEST; gd++) begin : g_dest
        assign dest_hit[gi][gd] = (head[gi][DEST_LSB +: DEST_W] == DEST_W'(gd));
      end
      assign valid[gi]    = |dest_hit[gi];
      assign eligible[gi] = !bus.empty_fifo_VC[gi] &&
                            (!valid[gi] || !(|(dest_hit[gi] & bus.full_D)));
    end
  endgenerate

  rr_arbiter #(
    .N    (N_VC),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (|eligible),
    .gnt     (gnt),
    .ptr     (rr_ptr)
  );

  always_comb begin
    sel_word = '0;
    sel_hit  = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (gnt[v]) begin
        sel_word = sel_word | head[v];
        sel_hit  = sel_hit | dest_hit[v];
      end
    end
  end

  assign drop_next = gnt & ~valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_D_reg     <= '0;
      data_out_D_reg <= '0;
      error_VC_reg   <= '0;
      err_count_reg  <= '0;
    end else begin
      push_D_reg   <= sel_hit;
      error_VC_reg <= drop_next;
      for (int d = 0; d < N_DEST; d++) begin
        if (sel_hit[d]) begin
          data_out_D_reg[d*W +: W] <= sel_word;
        end
      end
      if ((drop_next != '0) && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

  // The pop is combinational, so it is masked while reset is held.
  assign bus.pop_VC_fifo = reset ? '0 : gnt;
  assign bus.push_D      = push_D_reg;
  assign bus.data_out_D  = data_out_D_reg;
  assign bus.error_VC    = error_VC_reg;
  assign bus.err_count   = err_count_reg;

endmodule

// File: tb/tb_final_logic_router.sv
// Self-checking bench: a round-robin and a strict-priority router, with a
// scoreboard queue of expected push/error/count outcomes per grant cycle.
module tb_final_logic_router;
  import final_logic_pkg::*;

  localparam int W = 6, N_VC = 2, N_DEST = 2, DEST_W = 2, ERR_W = 8;

  typedef struct packed {
    logic [1:0] push;
    logic [5:0] data;
    logic [1:0] err;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  final_logic_router_if #(.W(W), .N_VC(N_VC), .N_DEST(N_DEST), .ERR_W(ERR_W)) bus_rr ();
  final_logic_router_if #(.W(W), .N_VC(N_VC), .N_DEST(N_DEST), .ERR_W(ERR_W)) bus_pr ();

  final_logic_router #(.W(W), .N_VC(N_VC), .N_DEST(N_DEST), .DEST_W(DEST_W),
                       .MODE(MODE_RR), .ERR_W(ERR_W))
    dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));

  final_logic_router #(.W(W), .N_VC(N_VC), .N_DEST(N_DEST), .DEST_W(DEST_W),
                       .MODE(MODE_PRIO), .ERR_W(ERR_W))
    dut_pr (.clk(clk), .reset(reset), .bus(bus_pr));

  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       q_pr[$];
  logic [7:0] exp_cnt = 8'd0;
  int         rr_last = N_VC - 1;

  function automatic logic elig(input logic [5:0] h, input logic empty, input logic [1:0] full);
    if (empty) return 1'b0;
    if (h[5:4] >= 2) return 1'b1;
    return !full[h[5:4]];
  endfunction

  function automatic logic [1:0] rr_pick(input logic [1:0] req);
    if (req == 2'b11) return (rr_last == 0) ? 2'b10 : 2'b01;
    return req;
  endfunction

  // Records what the router must show one cycle after granting g.
  task automatic expect_grant(input logic [1:0] g);
    exp_t e;
    logic [5:0] h;
    e = '0;
    if (g != 2'b00) begin
      h = g[0] ? bus_rr.data_out_VC[5:0] : bus_rr.data_out_VC[11:6];
      rr_last = g[0] ? 0 : 1;
      if (h[5:4] < 2) begin
        e.push = 2'b01 << h[5:4];
        e.data = h;
      end else begin
        e.err = g;
        if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      end
    end
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic drive_rr(input logic [5:0] h0, input logic [5:0] h1,
                          input logic [1:0] empty, input logic [1:0] full);
    bus_rr.data_out_VC   = {h1, h0};
    bus_rr.empty_fifo_VC = empty;
    bus_rr.full_D        = full;
  endtask

  task automatic test_reset();
    drive_rr(6'b010110, 6'b000000, 2'b10, 2'b00);
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (bus_rr.pop_VC_fifo !== 2'b00 || bus_rr.push_D !== 2'b00 || bus_rr.err_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold: pop=%b push=%b cnt=%0d, expected pop=00 push=00 cnt=0",
                 bus_rr.pop_VC_fifo, bus_rr.push_D, bus_rr.err_count);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus_rr.pop_VC_fifo !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_pop: pop=%b expected 01", bus_rr.pop_VC_fifo);
    end
    expect_grant(2'b01);
  endtask

  // Round-robin and backpressure share this loop; the table sets heads/full.
  task automatic test_traffic(input string name, input int n,
                              input logic [5:0] h0, input logic [5:0] h1a, input logic [5:0] h1b,
                              input int full_until, input int h1b_from);
    exp_t e;
    logic [1:0] full, p;
    logic [5:0] h1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (bus_rr.push_D !== e.push || bus_rr.error_VC !== e.err || bus_rr.err_count !== e.cnt) begin
        errors++;
        $display("FAIL %s_out[%0d]: push=%b err=%b cnt=%0d, expected push=%b err=%b cnt=%0d", name, i,
                 bus_rr.push_D, bus_rr.error_VC, bus_rr.err_count, e.push, e.err, e.cnt);
      end
      for (int d = 0; d < 2; d++) if (e.push[d]) begin
        checks++;
        if (bus_rr.data_out_D[d*W +: W] !== e.data) begin
          errors++;
          $display("FAIL %s_data[%0d] D%0d: got %b expected %b", name, i, d, bus_rr.data_out_D[d*W +: W], e.data);
        end
      end
      if (e.push != 0 || e.err != 0)
        $display("tx %s push=%b err=%b data=%b cnt=%0d", name, bus_rr.push_D, bus_rr.error_VC,
                 bus_rr.data_out_D, bus_rr.err_count);
      full = (i < full_until || i >= h1b_from) ? 2'b01 : 2'b00;
      h1   = (i >= h1b_from) ? h1b : h1a;
      drive_rr(h0, h1, 2'b00, full);
      #1;
      p = rr_pick({elig(h1, 1'b0, full), elig(h0, 1'b0, full)});
      checks++;
      if (bus_rr.pop_VC_fifo !== p) begin
        errors++;
        $display("FAIL %s_pop[%0d]: pop=%b expected %b", name, i, bus_rr.pop_VC_fifo, p);
      end
      expect_grant(p);
    end
  endtask

  task automatic test_invalid_dest();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (bus_rr.push_D !== e.push || bus_rr.error_VC !== e.err || bus_rr.err_count !== e.cnt) begin
        errors++;
        $display("FAIL invalid_out[%0d]: push=%b err=%b cnt=%0d, expected push=%b err=%b cnt=%0d", i,
                 bus_rr.push_D, bus_rr.error_VC, bus_rr.err_count, e.push, e.err, e.cnt);
      end
      for (int d = 0; d < 2; d++) if (e.push[d]) begin
        checks++;
        if (bus_rr.data_out_D[d*W +: W] !== e.data) begin
          errors++;
          $display("FAIL invalid_data[%0d]: got %b expected %b", i, bus_rr.data_out_D[d*W +: W], e.data);
        end
      end
      if (e.push != 0 || e.err != 0)
        $display("tx invalid push=%b err=%b cnt=%0d", bus_rr.push_D, bus_rr.error_VC, bus_rr.err_count);
      drive_rr(6'b110100, 6'b000000, 2'b10, 2'b00);
      #1;
      checks++;
      if (bus_rr.pop_VC_fifo !== 2'b01) begin
        errors++;
        $display("FAIL invalid_pop[%0d]: pop=%b expected 01", i, bus_rr.pop_VC_fifo);
      end
      expect_grant(2'b01);
    end
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus_rr.err_count !== 8'd255 || e.cnt !== 8'd255 || bus_rr.error_VC !== 2'b01) begin
      errors++;
      $display("FAIL invalid_saturate: cnt=%0d err=%b, expected cnt=255 err=01", bus_rr.err_count, bus_rr.error_VC);
    end
    $display("tx invalid err=%b cnt=%0d", bus_rr.error_VC, bus_rr.err_count);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive_rr(6'b000111, 6'b000000, 2'b10, 2'b00);
    #1;
    checks++;
    if (bus_rr.pop_VC_fifo !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pop: pop=%b expected 01", bus_rr.pop_VC_fifo);
    end
    expect_grant(2'b01);
    @(posedge clk); #2;
    checks++;
    if (bus_rr.push_D !== 2'b01 || bus_rr.data_out_D[5:0] !== 6'b000111) begin
      errors++;
      $display("FAIL midrst_pending: push=%b data=%b expected push=01 data=000111",
               bus_rr.push_D, bus_rr.data_out_D[5:0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus_rr.push_D !== 2'b00 || bus_rr.err_count !== 8'd0 || bus_rr.error_VC !== 2'b00 ||
        bus_rr.pop_VC_fifo !== 2'b00) begin
      errors++;
      $display("FAIL midrst_clear: push=%b cnt=%0d err=%b pop=%b expected all zero",
               bus_rr.push_D, bus_rr.err_count, bus_rr.error_VC, bus_rr.pop_VC_fifo);
    end
    q.delete();
    exp_cnt = 8'd0;
    rr_last = N_VC - 1;
    @(negedge clk);
    reset = 1'b0;
    drive_rr(6'b000111, 6'b010100, 2'b00, 2'b00);
    #1;
    checks++;
    if (bus_rr.pop_VC_fifo !== 2'b01) begin
      errors++;
      $display("FAIL midrst_first: pop=%b expected 01", bus_rr.pop_VC_fifo);
    end
    expect_grant(rr_pick(2'b11));
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (bus_rr.push_D !== e.push || bus_rr.data_out_D[5:0] !== e.data || bus_rr.err_count !== e.cnt) begin
      errors++;
      $display("FAIL midrst_out: push=%b data=%b cnt=%0d expected push=%b data=%b cnt=%0d",
               bus_rr.push_D, bus_rr.data_out_D[5:0], bus_rr.err_count, e.push, e.data, e.cnt);
    end
    $display("tx midrst push=%b data=%b", bus_rr.push_D, bus_rr.data_out_D[5:0]);
    drive_rr(6'b000000, 6'b000000, 2'b11, 2'b00);
  endtask

  task automatic test_priority();
    exp_t e;
    logic [1:0] p;
    bus_pr.data_out_VC = {6'b010001, 6'b000011};
    bus_pr.full_D      = 2'b00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (q_pr.size() != 0) begin
        e = q_pr.pop_front();
        checks++;
        if (bus_pr.push_D !== e.push || bus_pr.data_out_D[(e.push[1] ? W : 0) +: W] !== e.data) begin
          errors++;
          $display("FAIL prio_out[%0d]: push=%b data=%b expected push=%b data=%b", i,
                   bus_pr.push_D, bus_pr.data_out_D, e.push, e.data);
        end
        $display("tx prio push=%b data=%b", bus_pr.push_D, bus_pr.data_out_D);
      end
      if (i == 6) break;
      bus_pr.empty_fifo_VC = (i >= 4) ? 2'b01 : 2'b00;
      #1;
      p = (i >= 4) ? 2'b10 : 2'b01;
      checks++;
      if (bus_pr.pop_VC_fifo !== p) begin
        errors++;
        $display("FAIL prio_pop[%0d]: pop=%b expected %b", i, bus_pr.pop_VC_fifo, p);
      end
      e      = '0;
      e.push = p;
      e.data = p[0] ? 6'b000011 : 6'b010001;
      q_pr.push_back(e);
    end
    bus_pr.empty_fifo_VC = 2'b11;
  endtask

  initial begin
    bus_pr.data_out_VC   = '0;
    bus_pr.empty_fifo_VC = 2'b11;
    bus_pr.full_D        = 2'b00;
    test_reset();
    test_traffic("rr", 6, 6'b001101, 6'b010100, 6'b010100, 0, 1000);
    test_traffic("bp", 10, 6'b000001, 6'b000010, 6'b010111, 3, 7);
    test_invalid_dest();
    test_reset_mid();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
